// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter-sequencer state encoding and default byte width.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package uart_pkg;

  localparam int DefWordLength = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } uart_state_e;

  // Width of a saturating counter that must be able to hold 'cycles'.
  // The width never drops below one bit, so a disabled watchdog still has a legal vector.
  function automatic int cnt_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping modulo NumReq.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when to consume the grant.
module rr_arbiter #(
  parameter  int NumReq = 4,
  localparam int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              vld_o
);

  // Requester index that sits 'ofs' places above 'base', wrapping at NumReq.
  function automatic logic [IdxW-1:0] wrap_pos(input logic [IdxW-1:0] base, input int ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= NumReq) begin
      sum = sum - NumReq;
    end
    return IdxW'(sum);
  endfunction

  // Scan from the farthest offset down, so the request nearest the pointer is written last and wins.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    gnt_o = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_i[wrap_pos(ptr_i, i)]) begin
        idx_o = wrap_pos(ptr_i, i);
        vld_o = 1'b1;
      end
    end
    if (vld_o) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NumReq byte requesters, with a transmit watchdog.
// Latency: request in IDLE at cycle N -> grant and start pulse at N+1; ack/err one cycle after done/timeout.
// Backpressure: a requester holds req_i until ack_o; the done tick from the transmitter paces the sequencer.
// Optional: define UART_TX_ARB_LOCK_EN to add lock_i, which keeps priority on a requester across bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NumReq        = 4,
  parameter int WordLength    = DefWordLength,
  parameter int TimeoutCycles = 1000000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumReq-1:0]            req_i,
  input  logic [NumReq*WordLength-1:0] data_i,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NumReq-1:0]            lock_i,
`endif
  output logic [NumReq-1:0]            ack_o,
  output logic [NumReq-1:0]            gnt_o,
  output logic                         err_o,
  output logic                         busy_o,
  output logic [WordLength-1:0]        din_o,
  output logic                         start_tx_o,
  input  logic                         tx_done_tick_i
);

  localparam int              IdxW    = $clog2(NumReq);
  localparam int              CntW    = cnt_width(TimeoutCycles);
  localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  uart_state_e           r_state;
  uart_state_e           w_state_nxt;
  logic [IdxW-1:0]       r_ptr;
  logic [IdxW-1:0]       r_gidx;
  logic [IdxW-1:0]       w_arb_idx;
  logic [IdxW-1:0]       w_ptr_inc;
  logic [NumReq-1:0]     r_gnt;
  logic [NumReq-1:0]     r_ack;
  logic [NumReq-1:0]     w_arb_gnt;
  logic                  w_arb_vld;
  logic                  r_err;
  logic [WordLength-1:0] r_din;
  logic [CntW-1:0]       r_cnt;
  logic [CntW-1:0]       w_cnt_inc;
  logic                  w_timeout;
  logic                  w_grant;
  logic                  w_done;
  logic                  w_abort;
  logic                  w_hold_ptr;
  logic [WordLength-1:0] w_bytes [NumReq];

  for (genvar k = 0; k < NumReq; k++) begin : g_bytes
    assign w_bytes[k] = data_i[k*WordLength +: WordLength];
  end

  rr_arbiter #(
    .NumReq(NumReq)
  ) u_rr_arbiter (
    .req_i(req_i),
    .ptr_i(r_ptr),
    .gnt_o(w_arb_gnt),
    .idx_o(w_arb_idx),
    .vld_o(w_arb_vld)
  );

  // The count includes the current WAIT cycle, so the abort fires in the TimeoutCycles-th WAIT cycle.
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (TimeoutCycles != 0) && (w_cnt_inc == CntMax);
  assign w_ptr_inc = (r_gidx == LastIdx) ? '0 : r_gidx + 1'b1;

`ifdef UART_TX_ARB_LOCK_EN
  // A locked requester keeps the pointer so its next byte wins the following arbitration.
  assign w_hold_ptr = lock_i[r_gidx];
`else
  assign w_hold_ptr = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and one-cycle event strobes; a done tick takes precedence over a timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_vld) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_tick_i) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Grant/byte latches, completion pulses and priority pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gnt  <= '0;
      r_gidx <= '0;
      r_din  <= '0;
      r_ack  <= '0;
      r_err  <= 1'b0;
      r_ptr  <= '0;
    end else begin
      r_ack <= '0;
      r_err <= 1'b0;
      if (w_grant) begin
        r_gnt  <= w_arb_gnt;
        r_gidx <= w_arb_idx;
        r_din  <= w_bytes[w_arb_idx];
      end
      if (w_done) begin
        r_ack <= r_gnt;
        r_gnt <= '0;
        r_ptr <= w_hold_ptr ? r_gidx : w_ptr_inc;
      end
      if (w_abort) begin
        r_err <= 1'b1;
        r_gnt <= '0;
        r_ptr <= w_ptr_inc;
      end
    end
  end

  // Watchdog: cleared while issuing, then counts WAIT cycles and saturates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_cnt <= '0;
    end else if ((r_state == ST_WAIT) && (r_cnt != CntMax)) begin
      r_cnt <= w_cnt_inc;
    end
  end

  assign gnt_o      = r_gnt;
  assign ack_o      = r_ack;
  assign err_o      = r_err;
  assign din_o      = r_din;
  assign start_tx_o = (r_state == ST_ISSUE);
  assign busy_o     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, rotation, watchdog, tick/timeout race, async reset.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// The lock scenario is compiled in only when UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int WL = 8;
  localparam int TO = 50;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*WL-1:0] data = '0;
  logic [NR-1:0]    ack;
  logic [NR-1:0]    gnt;
  logic             err;
  logic             busy;
  logic [WL-1:0]    din;
  logic             start;
  logic             tick = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
  logic [NR-1:0]    lock = '0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NumReq(NR),
    .WordLength(WL),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_i(req),
    .data_i(data),
`ifdef UART_TX_ARB_LOCK_EN
    .lock_i(lock),
`endif
    .ack_o(ack),
    .gnt_o(gnt),
    .err_o(err),
    .busy_o(busy),
    .din_o(din),
    .start_tx_o(start),
    .tx_done_tick_i(tick)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    req = '0;
    tick = 1'b0;
    data = '0;
`ifdef UART_TX_ARB_LOCK_EN
    lock = '0;
`endif
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ack, gnt, err, busy, din, start} !== 19'd0) begin
      bad++;
      $display("FAIL reset_async got=%h exp=0", {ack, gnt, err, busy, din, start});
    end
    step(2);
    rst_n = 1'b1;
    step(1);
    total++;
    if ({ack, gnt, err, busy, din, start} !== 19'd0) begin
      bad++;
      $display("FAIL reset_release got=%h exp=0", {ack, gnt, err, busy, din, start});
    end
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    total++;
    if ({ack, err, busy, start} !== 7'd0) begin
      bad++;
      $display("FAIL idle_tick got=%b exp=0", {ack, err, busy, start});
    end
  endtask

  task automatic test_single();
    apply_reset();
    data[2*WL +: WL] = 8'hA5;
    req = 4'b0100;
    step(1);
    total++;
    if ({gnt, start, busy, din} !== {4'b0100, 1'b1, 1'b1, 8'hA5}) begin
      bad++;
      $display("FAIL single_issue got=%h exp=%h", {gnt, start, busy, din}, {4'b0100, 1'b1, 1'b1, 8'hA5});
    end
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    req = '0;
    total++;
    if ({gnt, start, busy, ack, err} !== {4'b0100, 1'b0, 1'b1, 4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL single_wait_tick_in_issue got=%b exp=%b", {gnt, start, busy, ack, err},
               {4'b0100, 1'b0, 1'b1, 4'b0000, 1'b0});
    end
    step(3);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    total++;
    if ({ack, gnt, busy, err, din} !== {4'b0100, 4'b0000, 1'b0, 1'b0, 8'hA5}) begin
      bad++;
      $display("FAIL single_ack got=%h exp=%h", {ack, gnt, busy, err, din},
               {4'b0100, 4'b0000, 1'b0, 1'b0, 8'hA5});
    end
    step(1);
    total++;
    if ({ack, busy} !== 5'd0) begin
      bad++;
      $display("FAIL single_ack_once got=%b exp=0", {ack, busy});
    end
  endtask

  task automatic test_rotation();
    logic [NR-1:0] eg;
    logic [WL-1:0] ed;
    apply_reset();
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'hF;
    step(1);
    for (int k = 0; k < 6; k++) begin
      eg = 4'b0001 << (k % 4);
      ed = 8'h10 + 8'(k % 4);
      total++;
      if ({gnt, start, din, ack} !== {eg, 1'b1, ed, 4'b0000}) begin
        bad++;
        $display("FAIL rot_issue k=%0d got=%h exp=%h", k, {gnt, start, din, ack}, {eg, 1'b1, ed, 4'b0000});
      end
      step(2);
      total++;
      if ({gnt, start, busy} !== {eg, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL rot_wait k=%0d got=%b exp=%b", k, {gnt, start, busy}, {eg, 1'b0, 1'b1});
      end
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      total++;
      if ({ack, err, gnt, busy} !== {eg, 1'b0, 4'b0000, 1'b0}) begin
        bad++;
        $display("FAIL rot_ack k=%0d got=%b exp=%b", k, {ack, err, gnt, busy}, {eg, 1'b0, 4'b0000, 1'b0});
      end
      step(1);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    data[1*WL +: WL] = 8'h5C;
    data[2*WL +: WL] = 8'h7E;
    req = 4'b0010;
    step(1);
    total++;
    if ({gnt, start, din} !== {4'b0010, 1'b1, 8'h5C}) begin
      bad++;
      $display("FAIL to_issue got=%h exp=%h", {gnt, start, din}, {4'b0010, 1'b1, 8'h5C});
    end
    req = 4'b0110;
    for (int c = 1; c <= TO; c++) begin
      step(1);
      total++;
      if ({err, ack, busy, gnt} !== {1'b0, 4'b0000, 1'b1, 4'b0010}) begin
        bad++;
        $display("FAIL to_waiting c=%0d got=%b exp=%b", c, {err, ack, busy, gnt},
                 {1'b0, 4'b0000, 1'b1, 4'b0010});
      end
    end
    step(1);
    total++;
    if ({err, ack, busy, gnt} !== {1'b1, 4'b0000, 1'b0, 4'b0000}) begin
      bad++;
      $display("FAIL to_err got=%b exp=%b", {err, ack, busy, gnt}, {1'b1, 4'b0000, 1'b0, 4'b0000});
    end
    step(1);
    total++;
    if ({gnt, start, err, din} !== {4'b0100, 1'b1, 1'b0, 8'h7E}) begin
      bad++;
      $display("FAIL to_next_grant got=%h exp=%h", {gnt, start, err, din}, {4'b0100, 1'b1, 1'b0, 8'h7E});
    end
  endtask

  task automatic test_tick_vs_timeout();
    apply_reset();
    req = 4'b0001;
    step(1);
    req = '0;
    step(TO);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    total++;
    if ({ack, err, busy} !== {4'b0001, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL race_ack got=%b exp=%b", {ack, err, busy}, {4'b0001, 1'b0, 1'b0});
    end
    step(1);
    total++;
    if ({ack, err} !== 5'd0) begin
      bad++;
      $display("FAIL race_after got=%b exp=0", {ack, err});
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b0010;
    step(1);
    req = '0;
    step(1);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    req = 4'b1100;
    step(1);
    total++;
    if ({gnt, din} !== {4'b0100, 8'h33}) begin
      bad++;
      $display("FAIL rmid_grant got=%h exp=%h", {gnt, din}, {4'b0100, 8'h33});
    end
    step(2);
    rst_n = 1'b0;
    #1;
    total++;
    if ({ack, gnt, err, busy, din, start} !== 19'd0) begin
      bad++;
      $display("FAIL rmid_async got=%h exp=0", {ack, gnt, err, busy, din, start});
    end
    step(1);
    req = 4'b1001;
    rst_n = 1'b1;
    step(1);
    total++;
    if ({gnt, din, start, ack, err} !== {4'b0001, 8'h11, 1'b1, 4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL rmid_ptr0 got=%h exp=%h", {gnt, din, start, ack, err},
               {4'b0001, 8'h11, 1'b1, 4'b0000, 1'b0});
    end
  endtask

`ifdef UART_TX_ARB_LOCK_EN
  task automatic test_lock();
    logic [NR-1:0] eg;
    apply_reset();
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b0110;
    step(1);
    for (int k = 0; k < 4; k++) begin
      eg = (k < 3) ? 4'b0010 : 4'b0100;
      total++;
      if ({gnt, start} !== {eg, 1'b1}) begin
        bad++;
        $display("FAIL lock_grant k=%0d got=%b exp=%b", k, {gnt, start}, {eg, 1'b1});
      end
      lock = (k < 2) ? 4'b0010 : 4'b0000;
      step(2);
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      total++;
      if ({ack, err} !== {eg, 1'b0}) begin
        bad++;
        $display("FAIL lock_ack k=%0d got=%b exp=%b", k, {ack, err}, {eg, 1'b0});
      end
      step(1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_tick_vs_timeout();
    test_reset_mid();
`ifdef UART_TX_ARB_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
